// File: rtl/load_store_unit_if.sv
// Pipeline memory-stage request/response and external data-memory port bundle
// shared between the pipeline, load_store_unit and the data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output stall, done, err, rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  stall, done, err, rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one memory-stage load or store into a single
// external memory transaction, with misalignment and timeout aborts.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{wdata[7:0]}};
            2'b01:   w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] addr_lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic        misalign_s;
    logic        timeout_s;
    logic        stall_s;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  addr_lo_r;
    logic        err_r;
    logic [31:0] rdata_r;

    // Next-state decode, alignment check, timeout detect and pipeline stall
    always_comb begin
        state_nxt_s = state_r;
        misalign_s  = 1'b0;
        case (bus.req_size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = bus.req_addr[0];
            default: misalign_s = (bus.req_addr[1:0] != 2'b00);
        endcase
        // completion on the limit cycle wins over the timeout
        timeout_s = (state_r == ST_ACCESS) && !bus.mem_ready && (cnt_r == LAST_CNT);
        stall_s   = !rst && (((state_r == ST_IDLE) && bus.req_valid) || (state_r == ST_ACCESS));
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (misalign_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCESS;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ready || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cycles spent in ACCESS without mem_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (state_r == ST_ACCESS) begin
            if (!bus.mem_ready) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= 8'd0;
        end
    end

    // Memory request fields, frozen for the whole ACCESS phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_be_r    <= 4'd0;
            mem_wdata_r <= 32'd0;
            size_r      <= 2'd0;
            signed_r    <= 1'b0;
            addr_lo_r   <= 2'd0;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_ACCESS)) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.req_we;
            mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
            mem_be_r    <= calc_be(bus.req_size, bus.req_addr[1:0]);
            mem_wdata_r <= calc_wdata(bus.req_size, bus.req_wdata);
            size_r      <= bus.req_size;
            signed_r    <= bus.req_signed;
            addr_lo_r   <= bus.req_addr[1:0];
        end else if ((state_r == ST_ACCESS) && (state_nxt_s == ST_DONE)) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end else begin
            mem_req_r <= mem_req_r;
            mem_we_r  <= mem_we_r;
        end
    end

    // Response data and error flag, live only during the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    err_r   <= bus.req_valid && misalign_s;
                    rdata_r <= 32'd0;
                end
                ST_ACCESS: begin
                    if (bus.mem_ready) begin
                        err_r <= 1'b0;
                        if (mem_we_r) begin
                            rdata_r <= 32'd0;
                        end else begin
                            rdata_r <= extract_load(bus.mem_rdata, size_r, signed_r, addr_lo_r);
                        end
                    end else begin
                        err_r   <= timeout_s;
                        rdata_r <= 32'd0;
                    end
                end
                default: begin
                    err_r   <= 1'b0;
                    rdata_r <= 32'd0;
                end
            endcase
        end
    end

    assign bus.stall     = stall_s;
    assign bus.done      = (state_r == ST_DONE);
    assign bus.err       = err_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule
